// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port-count defaults, the per-output
// ownership FSM encoding and a round-robin pointer helper.
package noc_pkg;

    localparam int PORTS_DEFAULT         = 5;
    localparam int REQUEST_WIDTH_DEFAULT = $clog2(PORTS_DEFAULT);

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } out_state_e;

    // Pointer value that follows a grant to input idx, wrapping at ports.
    function automatic int rr_next(input int idx, input int ports);
        if (idx + 1 >= ports) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the router input buffers (master) and the
// switch allocator (slave), plus the crossbar select it produces.
interface switch_allocator_if #(
    parameter int PORTS         = noc_pkg::PORTS_DEFAULT,
    parameter int REQUEST_WIDTH = noc_pkg::REQUEST_WIDTH_DEFAULT
);

    logic [PORTS-1:0]               routeReserveRequestValid;
    logic [PORTS*REQUEST_WIDTH-1:0] routeReserveRequest;
    logic [PORTS-1:0]               routeRelieve;
    logic [PORTS-1:0]               routeReserveStatus;
    logic [PORTS-1:0]               outLocked;
    logic [PORTS*REQUEST_WIDTH-1:0] outSelect;

    modport master (
        output routeReserveRequestValid,
        output routeReserveRequest,
        output routeRelieve,
        input  routeReserveStatus,
        input  outLocked,
        input  outSelect
    );

    modport slave (
        input  routeReserveRequestValid,
        input  routeReserveRequest,
        input  routeRelieve,
        output routeReserveStatus,
        output outLocked,
        output outSelect
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester closest to ptr, counting
// upward with wrap-around, wins a one-hot grant.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int PORTS     = PORTS_DEFAULT,
    parameter int PTR_WIDTH = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]     req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [PORTS-1:0]     gnt,
    output logic                 valid
);

    int best_dist_s;
    int winner_s;

    // Find the requester with the smallest rotational distance from ptr.
    always_comb begin
        best_dist_s = PORTS;
        winner_s    = 0;
        for (int i = 0; i < PORTS; i++) begin
            if (req[i] && (((i + PORTS - int'(ptr)) % PORTS) < best_dist_s)) begin
                best_dist_s = (i + PORTS - int'(ptr)) % PORTS;
                winner_s    = i;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Expand the winner into a one-hot grant qualified by any request.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < PORTS; i++) begin
            gnt[i] = req[i] && (winner_s == i);
        end
        valid = |req;
    end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: each output is a FREE/LOCKED FSM that is claimed by
// one input through its own round-robin arbiter and held until that input relieves.
module switch_allocator
    import noc_pkg::*;
#(
    parameter int PORTS         = PORTS_DEFAULT,
    parameter int REQUEST_WIDTH = $clog2(PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORTS-1:0]               routeReserveRequestValid,
    input  logic [PORTS*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [PORTS-1:0]               routeRelieve,
    output logic [PORTS-1:0]               routeReserveStatus,
    output logic [PORTS-1:0]               outLocked,
    output logic [PORTS*REQUEST_WIDTH-1:0] outSelect
);

    out_state_e               state_r    [PORTS];
    logic [REQUEST_WIDTH-1:0] owner_r    [PORTS];
    logic [REQUEST_WIDTH-1:0] ptr_r      [PORTS];
    logic [PORTS-1:0]         status_r;

    logic [PORTS-1:0]         owns_s;
    logic [PORTS-1:0]         relieve_s;
    logic [PORTS-1:0]         req_vec_s  [PORTS];
    logic [PORTS-1:0]         gnt_s      [PORTS];
    logic [PORTS-1:0]         gnt_valid_s;
    logic [REQUEST_WIDTH-1:0] gnt_idx_s  [PORTS];
    logic [REQUEST_WIDTH-1:0] ptr_next_s [PORTS];
    logic [PORTS-1:0]         status_next_s;

    // Which inputs currently own an output, and which outputs their owner releases.
    always_comb begin
        owns_s    = '0;
        relieve_s = '0;
        for (int o = 0; o < PORTS; o++) begin
            for (int i = 0; i < PORTS; i++) begin
                if ((state_r[o] == LOCKED) && (owner_r[o] == REQUEST_WIDTH'(i))) begin
                    owns_s[i]    = 1'b1;
                    relieve_s[o] = relieve_s[o] | routeRelieve[i];
                end else begin
                    owns_s[i]    = owns_s[i];
                end
            end
        end
    end

    // Per-output request vectors; owners and out-of-range indices never match.
    always_comb begin
        for (int o = 0; o < PORTS; o++) begin
            req_vec_s[o] = '0;
            for (int i = 0; i < PORTS; i++) begin
                req_vec_s[o][i] = routeReserveRequestValid[i] && !owns_s[i] &&
                    (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o));
            end
        end
    end

    for (genvar o = 0; o < PORTS; o++) begin : g_out
        rr_arbiter #(
            .PORTS     (PORTS),
            .PTR_WIDTH (REQUEST_WIDTH)
        ) u_arb (
            .req   (req_vec_s[o]),
            .ptr   (ptr_r[o]),
            .gnt   (gnt_s[o]),
            .valid (gnt_valid_s[o])
        );

        assign outLocked[o]                                    = (state_r[o] == LOCKED);
        assign outSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH]     = owner_r[o];
    end

    // Encode winners, advance pointers and form grant pulses for FREE outputs only.
    always_comb begin
        status_next_s = '0;
        for (int o = 0; o < PORTS; o++) begin
            gnt_idx_s[o]  = '0;
            ptr_next_s[o] = ptr_r[o];
            for (int i = 0; i < PORTS; i++) begin
                if (gnt_s[o][i]) begin
                    gnt_idx_s[o]  = REQUEST_WIDTH'(i);
                    ptr_next_s[o] = REQUEST_WIDTH'(rr_next(i, PORTS));
                end else begin
                    gnt_idx_s[o]  = gnt_idx_s[o];
                end
                status_next_s[i] = status_next_s[i] |
                    ((state_r[o] == FREE) && gnt_valid_s[o] && gnt_s[o][i]);
            end
        end
    end

    // Output FSMs: a LOCKED output only frees here, so it cannot be regranted on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < PORTS; o++) begin
                state_r[o] <= FREE;
                owner_r[o] <= '0;
                ptr_r[o]   <= '0;
            end
            status_r <= '0;
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                case (state_r[o])
                    FREE: begin
                        if (gnt_valid_s[o]) begin
                            state_r[o] <= LOCKED;
                            owner_r[o] <= gnt_idx_s[o];
                            ptr_r[o]   <= ptr_next_s[o];
                        end else begin
                            state_r[o] <= FREE;
                        end
                    end
                    LOCKED: begin
                        if (relieve_s[o]) begin
                            state_r[o] <= FREE;
                        end else begin
                            state_r[o] <= LOCKED;
                        end
                    end
                    default: begin
                        state_r[o] <= FREE;
                    end
                endcase
            end
            status_r <= status_next_s;
        end
    end

    assign routeReserveStatus = status_r;

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed vector table, reset
// sequences and randomized traffic against an ownership/round-robin model.
module tb_switch_allocator;

    localparam int P = 5;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    switch_allocator_if #(.PORTS(P), .REQUEST_WIDTH(W)) bus ();

    switch_allocator #(.PORTS(P), .REQUEST_WIDTH(W)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (bus.routeReserveRequestValid),
        .routeReserveRequest      (bus.routeReserveRequest),
        .routeRelieve             (bus.routeRelieve),
        .routeReserveStatus       (bus.routeReserveStatus),
        .outLocked                (bus.outLocked),
        .outSelect                (bus.outSelect)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [P-1:0]   valid;
        logic [P*W-1:0] req;
        logic [P-1:0]   relieve;
        logic [P-1:0]   st;
        logic [P-1:0]   lk;
        logic [P*W-1:0] sel;
    } vec_t;

    vec_t vecs[$];

    int m_owner[P];
    int m_sel[P];
    int m_ptr[P];

    function automatic logic [P*W-1:0] pk(input int s4, input int s3, input int s2,
                                          input int s1, input int s0);
        return {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    task automatic add(input string n, input logic [P-1:0] v, input logic [P*W-1:0] r,
                       input logic [P-1:0] rl, input logic [P-1:0] st,
                       input logic [P-1:0] lk, input logic [P*W-1:0] sel);
        vec_t x;
        x.name = n; x.valid = v; x.req = r; x.relieve = rl;
        x.st = st; x.lk = lk; x.sel = sel;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [P-1:0] v, input logic [P*W-1:0] r, input logic [P-1:0] rl);
        bus.routeReserveRequestValid = v;
        bus.routeReserveRequest      = r;
        bus.routeRelieve             = rl;
    endtask

    task automatic check_outputs(input string tag, input logic [P-1:0] st,
                                 input logic [P-1:0] lk, input logic [P*W-1:0] sel);
        check({tag, ".status"}, 32'(bus.routeReserveStatus), 32'(st));
        check({tag, ".locked"}, 32'(bus.outLocked), 32'(lk));
        check({tag, ".select"}, 32'(bus.outSelect), 32'(sel));
    endtask

    function automatic void model_reset();
        for (int o = 0; o < P; o++) begin
            m_owner[o] = -1;
            m_sel[o]   = 0;
            m_ptr[o]   = 0;
        end
    endfunction

    // One clock edge of the allocator rules, evaluated on the pre-edge ownership.
    function automatic void model_step(input logic [P-1:0] v, input logic [P*W-1:0] r,
                                       input logic [P-1:0] rl, output logic [P-1:0] st);
        bit busy[P];
        int nxt[P];
        int cand;
        st = '0;
        for (int i = 0; i < P; i++) busy[i] = 1'b0;
        for (int o = 0; o < P; o++) begin
            nxt[o] = m_owner[o];
            if (m_owner[o] >= 0) busy[m_owner[o]] = 1'b1;
        end
        for (int o = 0; o < P; o++) begin
            if (m_owner[o] >= 0) begin
                if (rl[m_owner[o]]) nxt[o] = -1;
            end else begin
                for (int k = 0; k < P; k++) begin
                    cand = (m_ptr[o] + k) % P;
                    if (nxt[o] < 0 && v[cand] && !busy[cand] && int'(r[cand*W +: W]) == o) begin
                        nxt[o]   = cand;
                        m_sel[o] = cand;
                        st[cand] = 1'b1;
                    end
                end
                if (nxt[o] >= 0) m_ptr[o] = (nxt[o] + 1) % P;
            end
        end
        for (int o = 0; o < P; o++) m_owner[o] = nxt[o];
    endfunction

    initial begin
        logic [P-1:0]   rv;
        logic [P-1:0]   rrl;
        logic [P*W-1:0] rr;
        logic [P-1:0]   est;
        logic [P-1:0]   elk;
        logic [P*W-1:0] esel;

        //   name          valid     req               relieve   status    locked    select
        add("idle",        5'b00000, pk(0,0,0,0,0),    5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0));
        add("single",      5'b00100, pk(0,0,3,0,0),    5'b00000, 5'b00100, 5'b01000, pk(0,2,0,0,0));
        add("no_regrant",  5'b00100, pk(0,0,3,0,0),    5'b00000, 5'b00000, 5'b01000, pk(0,2,0,0,0));
        add("hold_sel",    5'b00000, pk(0,0,0,0,0),    5'b00100, 5'b00000, 5'b00000, pk(0,2,0,0,0));
        add("cont_0",      5'b10011, pk(1,0,0,1,1),    5'b00000, 5'b00001, 5'b00010, pk(0,2,0,0,0));
        add("cont_rel0",   5'b10011, pk(1,0,0,1,1),    5'b00001, 5'b00000, 5'b00000, pk(0,2,0,0,0));
        add("cont_1",      5'b10011, pk(1,0,0,1,1),    5'b00000, 5'b00010, 5'b00010, pk(0,2,0,1,0));
        add("cont_rel1",   5'b10011, pk(1,0,0,1,1),    5'b00010, 5'b00000, 5'b00000, pk(0,2,0,1,0));
        add("cont_4",      5'b10011, pk(1,0,0,1,1),    5'b00000, 5'b10000, 5'b00010, pk(0,2,0,4,0));
        add("cont_rel4",   5'b00000, pk(0,0,0,0,0),    5'b10000, 5'b00000, 5'b00000, pk(0,2,0,4,0));
        add("ptr_wrap",    5'b10001, pk(1,0,0,0,1),    5'b00000, 5'b00001, 5'b00010, pk(0,2,0,0,0));
        add("ptr_rel",     5'b00000, pk(0,0,0,0,0),    5'b00001, 5'b00000, 5'b00000, pk(0,2,0,0,0));
        add("rg_lock",     5'b00001, pk(0,0,0,0,2),    5'b00000, 5'b00001, 5'b00100, pk(0,2,0,0,0));
        add("rg_release",  5'b01000, pk(0,2,0,0,0),    5'b00001, 5'b00000, 5'b00000, pk(0,2,0,0,0));
        add("rg_grant",    5'b01000, pk(0,2,0,0,0),    5'b00000, 5'b01000, 5'b00100, pk(0,2,3,0,0));
        add("rg_rel",      5'b00000, pk(0,0,0,0,0),    5'b01000, 5'b00000, 5'b00000, pk(0,2,3,0,0));
        add("parallel",    5'b11111, pk(0,1,2,3,4),    5'b00000, 5'b11111, 5'b11111, pk(0,1,2,3,4));
        add("par_rel",     5'b00000, pk(0,0,0,0,0),    5'b11111, 5'b00000, 5'b00000, pk(0,1,2,3,4));
        add("illegal7",    5'b00010, pk(0,0,0,7,0),    5'b00000, 5'b00000, 5'b00000, pk(0,1,2,3,4));
        add("dup_first",   5'b00010, pk(0,0,0,0,0),    5'b00000, 5'b00010, 5'b00001, pk(0,1,2,3,1));
        add("dup_second",  5'b00010, pk(0,0,0,4,0),    5'b00000, 5'b00000, 5'b00001, pk(0,1,2,3,1));
        add("dup_rel",     5'b00000, pk(0,0,0,0,0),    5'b00010, 5'b00000, 5'b00000, pk(0,1,2,3,1));

        drive('0, '0, '0);
        #2;
        check_outputs("reset_async", 5'b00000, 5'b00000, pk(0,0,0,0,0));
        #10 rst = 1'b1;
        @(posedge clk); #1;
        check_outputs("reset_first_edge", 5'b00000, 5'b00000, pk(0,0,0,0,0));

        foreach (vecs[k]) begin
            drive(vecs[k].valid, vecs[k].req, vecs[k].relieve);
            @(posedge clk); #1;
            check_outputs(vecs[k].name, vecs[k].st, vecs[k].lk, vecs[k].sel);
        end

        // Mid-cycle reset while two outputs are locked and their grants are pulsing.
        drive(5'b00011, pk(0,0,0,3,2), 5'b00000);
        @(posedge clk); #1;
        check_outputs("pre_reset", 5'b00011, 5'b01100, pk(0,1,0,3,1));
        drive('0, '0, '0);
        #3 rst = 1'b0;
        #1;
        check_outputs("reset_midcycle", 5'b00000, 5'b00000, pk(0,0,0,0,0));
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs("post_reset_idle", 5'b00000, 5'b00000, pk(0,0,0,0,0));
        drive(5'b01001, pk(0,2,0,0,2), 5'b00000);
        @(posedge clk); #1;
        check_outputs("post_reset_ptr", 5'b00001, 5'b00100, pk(0,0,0,0,0));
        drive('0, '0, 5'b00001);
        @(posedge clk); #1;
        check_outputs("post_reset_rel", 5'b00000, 5'b00000, pk(0,0,0,0,0));

        #3 rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();

        for (int n = 0; n < 400; n++) begin
            rv  = P'($urandom);
            rrl = '0;
            for (int i = 0; i < P; i++) begin
                if ($urandom_range(0, 9) == 0) rr[i*W +: W] = 3'($urandom_range(5, 7));
                else                           rr[i*W +: W] = 3'($urandom_range(0, 4));
                rrl[i] = ($urandom_range(0, 3) == 0);
            end
            model_step(rv, rr, rrl, est);
            for (int o = 0; o < P; o++) begin
                elk[o]         = (m_owner[o] >= 0);
                esel[o*W +: W] = 3'(m_sel[o]);
            end
            drive(rv, rr, rrl);
            @(posedge clk); #1;
            check_outputs("random", est, elk, esel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
